elevator_ctrl: RTL and testbench

Elevator car controller fed by the request buffer's latched `upcall`, `downcall` and `floor_btn` vectors. It runs a SCAN (collective) scheduling state machine, moves the car one floor per travel interval, and opens the door for a fixed interval. It drives back `floor` and `openflag`, which the request buffer uses to clear served requests at the current floor.

---
 rtl/elev_pkg.sv | 18 +
 rtl/elev_req_decode.sv | 50 +++++
 rtl/elevator_ctrl.sv | 139 +++++++++++++
 tb/tb_elevator_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared state type, floor-width helper and default timing for the elevator controller
package elev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } elev_state_t;

  localparam int DEF_NFLOORS    = 8;
  localparam int DEF_TRAVEL_CYC = 16;
  localparam int DEF_DOOR_CYC   = 32;

  function automatic int floor_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elev_req_decode.sv
// rtl/elev_req_decode.sv - combinational request decode: above, below, request here and SCAN stop decision
module elev_req_decode
  import elev_pkg::*;
#(
  parameter int NFLOORS = DEF_NFLOORS,
  localparam int FW = floor_w(NFLOORS)
) (
  input  logic [NFLOORS-1:0] upcall,
  input  logic [NFLOORS-1:0] downcall,
  input  logic [NFLOORS-1:0] floor_btn,
  input  logic [FW-1:0]      floor,
  input  logic               dir_up,
  output logic               above,
  output logic               below,
  output logic               req_here,
  output logic               stop_here
);

  logic [NFLOORS-1:0] req;
  logic               up_here;
  logic               dn_here;
  logic               btn_here;

  assign req = upcall | downcall | floor_btn;

  // Loop-based select keeps non-power-of-two floor counts safe from out-of-range indexing
  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    req_here = 1'b0;
    up_here  = 1'b0;
    dn_here  = 1'b0;
    btn_here = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (req[i] && (i > int'(floor))) above = 1'b1;
      if (req[i] && (i < int'(floor))) below = 1'b1;
      if (i == int'(floor)) begin
        req_here = req[i];
        up_here  = upcall[i];
        dn_here  = downcall[i];
        btn_here = floor_btn[i];
      end
    end
  end

  // A hall call against the travel direction is only served once nothing lies further ahead
  assign stop_here = btn_here | (dir_up ? (up_here | (dn_here & ~above))
                                        : (dn_here | (up_here & ~below)));

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN elevator car controller: IDLE/MOVE/DOOR FSM with travel and door timers
// Optional door-hold input enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_ctrl
  import elev_pkg::*;
#(
  parameter int NFLOORS    = DEF_NFLOORS,
  parameter int TRAVEL_CYC = DEF_TRAVEL_CYC,
  parameter int DOOR_CYC   = DEF_DOOR_CYC,
  localparam int FW = floor_w(NFLOORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] upcall,
  input  logic [NFLOORS-1:0] downcall,
  input  logic [NFLOORS-1:0] floor_btn,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic               door_hold,
`endif
  output logic [FW-1:0]      floor,
  output logic               openflag,
  output logic               dir_up,
  output logic               moving
);

  localparam int TW = $clog2(TRAVEL_CYC);
  localparam int DW = $clog2(DOOR_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYC - 1);
  localparam logic [FW-1:0] TOP    = FW'(NFLOORS - 1);

  elev_state_t   state, state_n;
  logic [FW-1:0] floor_n;
  logic          dir_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic          arrived, arrived_n;
  logic          above, below, req_here, stop_here;
  logic          ahead, behind;
  logic          hold;

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  elev_req_decode #(.NFLOORS(NFLOORS)) u_decode (
    .upcall    (upcall),
    .downcall  (downcall),
    .floor_btn (floor_btn),
    .floor     (floor),
    .dir_up    (dir_up),
    .above     (above),
    .below     (below),
    .req_here  (req_here),
    .stop_here (stop_here)
  );

  assign ahead  = dir_up ? above : below;
  assign behind = dir_up ? below : above;

  always_comb begin
    state_n   = state;
    floor_n   = floor;
    dir_n     = dir_up;
    tcnt_n    = tcnt;
    dcnt_n    = dcnt;
    arrived_n = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        dcnt_n = '0;
        if (req_here) begin
          state_n = DOOR;
        end else if (ahead) begin
          state_n = MOVE;
        end else if (behind) begin
          state_n = MOVE;
          dir_n   = ~dir_up;
        end
      end
      MOVE: begin
        // The arrival cycle decides with the freshly updated floor; the timer keeps running
        if (arrived && stop_here) begin
          state_n = DOOR;
          tcnt_n  = '0;
          dcnt_n  = '0;
        end else if (arrived && !ahead && !behind) begin
          state_n = IDLE;
          tcnt_n  = '0;
        end else begin
          if (arrived && !ahead) dir_n = ~dir_up;
          if (tcnt == T_LAST) begin
            tcnt_n    = '0;
            arrived_n = 1'b1;
            if (dir_n) floor_n = (floor == TOP)  ? floor : floor + FW'(1);
            else       floor_n = (floor == '0)   ? floor : floor - FW'(1);
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
      end
      DOOR: begin
        if (hold) begin
          dcnt_n = '0;
        end else if (dcnt == D_LAST) begin
          state_n = IDLE;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor    <= '0;
      dir_up   <= 1'b1;
      tcnt     <= '0;
      dcnt     <= '0;
      arrived  <= 1'b0;
      openflag <= 1'b0;
      moving   <= 1'b0;
    end else begin
      state    <= state_n;
      floor    <= floor_n;
      dir_up   <= dir_n;
      tcnt     <= tcnt_n;
      dcnt     <= dcnt_n;
      arrived  <= arrived_n;
      openflag <= (state_n == DOOR);
      moving   <= (state_n == MOVE);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - directed self-checking bench for elevator_ctrl (TRAVEL_CYC=4, DOOR_CYC=6)
module tb_elevator_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] upcall, downcall, floor_btn;
  logic       door_hold;
  logic [2:0] floor;
  logic       openflag, dir_up, moving;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  elevator_ctrl #(.NFLOORS(8), .TRAVEL_CYC(4), .DOOR_CYC(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .upcall    (upcall),
    .downcall  (downcall),
    .floor_btn (floor_btn),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .floor     (floor),
    .openflag  (openflag),
    .dir_up    (dir_up),
    .moving    (moving)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int f, input int o, input int d, input int m);
    check({tag, "_floor"}, int'(floor), f);
    check({tag, "_open"}, int'(openflag), o);
    check({tag, "_dir"}, int'(dir_up), d);
    check({tag, "_moving"}, int'(moving), m);
  endtask

  initial begin
    rst = 1'b1; upcall = '0; downcall = '0; floor_btn = '0; door_hold = 1'b0;
    tick(2);
    check_state("reset", 0, 0, 1, 0);
    rst = 1'b0;
    tick(1);
    check_state("idle_after_reset", 0, 0, 1, 0);

    // Door at current floor
    floor_btn = 8'h01;
    tick(1);
    check_state("door_f0_open", 0, 1, 1, 0);
    floor_btn = '0;
    tick(5);
    check("door_f0_last", int'(openflag), 1);
    tick(1);
    check_state("door_f0_closed", 0, 0, 1, 0);

    // Travel 0 -> 5
    floor_btn = 8'h20;
    tick(1);
    check_state("move5_start", 0, 0, 1, 1);
    for (int f = 1; f <= 5; f++) begin
      tick(4);
      check_state("move5_step", f, 0, 1, 1);
    end
    tick(1);
    check_state("move5_arrive", 5, 1, 1, 0);
    floor_btn = '0;
    tick(6);
    check_state("move5_idle", 5, 0, 1, 0);

    // Pass downcall[4] going up, serve upcall[6], reverse, serve downcall[4]
    rst = 1'b1; tick(1); rst = 1'b0;
    upcall = 8'h40; downcall = 8'h10;
    tick(1);
    check_state("scan_start", 0, 0, 1, 1);
    tick(16);
    check("scan_at4", int'(floor), 4);
    tick(1);
    check_state("scan_pass4", 4, 0, 1, 1);
    tick(7);
    check("scan_at6", int'(floor), 6);
    tick(1);
    check_state("scan_stop6", 6, 1, 1, 0);
    upcall = '0;
    tick(6);
    check_state("scan_idle6", 6, 0, 1, 0);
    tick(1);
    check_state("scan_reverse", 6, 0, 0, 1);
    tick(8);
    check("scan_back4", int'(floor), 4);
    tick(1);
    check_state("scan_stop4", 4, 1, 0, 0);
    downcall = '0;
    tick(6);
    check("scan_close4", int'(openflag), 0);

    // Top floor, then sweep down to upcall[0]
    rst = 1'b1; tick(1); rst = 1'b0;
    floor_btn = 8'h80;
    tick(1);
    check("top_start_moving", int'(moving), 1);
    tick(4);
    check("top_f1", int'(floor), 1);
    upcall = 8'h01;
    tick(24);
    check("top_f7", int'(floor), 7);
    tick(1);
    check_state("top_open", 7, 1, 1, 0);
    floor_btn = '0;
    tick(6);
    check_state("top_idle", 7, 0, 1, 0);
    tick(1);
    check_state("top_reverse", 7, 0, 0, 1);
    for (int k = 1; k <= 7; k++) begin
      tick(4);
      check("top_down_step", int'(floor), 7 - k);
    end
    tick(1);
    check_state("bottom_open", 0, 1, 0, 0);
    upcall = '0;
    tick(6);
    check_state("bottom_idle", 0, 0, 0, 0);

    // Reset mid-travel
    floor_btn = 8'h80;
    tick(1);
    check_state("rst_mid_start", 0, 0, 1, 1);
    tick(12);
    check_state("rst_mid_f3", 3, 0, 1, 1);
    tick(2);
    rst = 1'b1;
    floor_btn = '0;
    tick(1);
    check_state("rst_mid", 0, 0, 1, 0);
    rst = 1'b0;
    tick(3);
    check_state("rst_mid_idle", 0, 0, 1, 0);

`ifdef ELEV_DOOR_HOLD_EN
    floor_btn = 8'h01;
    tick(1);
    check("hold_open", int'(openflag), 1);
    floor_btn = '0;
    door_hold = 1'b1;
    tick(20);
    check("hold_held", int'(openflag), 1);
    door_hold = 1'b0;
    tick(5);
    check("hold_release_last", int'(openflag), 1);
    tick(1);
    check("hold_closed", int'(openflag), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
